// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg: shared state encoding and lane constants for the FP_Adder host sequencer.
package fp_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int LANES_DEF = 4;
  localparam int HALF_BITS = WIDTH_DEF / 2;

  // Lane order as seen on the adder's serial1..serial4 inputs
  localparam int LANE_A_HI = 0;
  localparam int LANE_A_LO = 1;
  localparam int LANE_B_HI = 2;
  localparam int LANE_B_LO = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SHIFT    = 3'd2,
    WRITE    = 3'd3,
    WAIT_RES = 3'd4,
    READ     = 3'd5,
    DONE     = 3'd6
  } seq_state_e;

endpackage

// File: rtl/fp_seq_oclk_gen.sv
// fp_seq_oclk_gen: output-clock phase generator for the result read-back.
// Phase stays low and the divider is cleared whenever en is low.
module fp_seq_oclk_gen #(
  parameter int OCLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic oclk,
  output logic sample,
  output logic bit_done
);

  localparam int CW = (OCLK_DIV > 1) ? $clog2(OCLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(OCLK_DIV - 1);

  logic [CW-1:0] div_cnt_r;
  logic          last_s;

  assign last_s   = (div_cnt_r == LAST);
  // Last low cycle of a bit: data from the adder has been stable the whole low phase
  assign sample   = en & ~oclk & last_s;
  assign bit_done = en & oclk & last_s;

  // Divider and phase register; oclk itself is the registered phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_r <= '0;
      oclk      <= 1'b0;
    end else if (!en) begin
      div_cnt_r <= '0;
      oclk      <= 1'b0;
    end else if (last_s) begin
      div_cnt_r <= '0;
      oclk      <= ~oclk;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/fp_adder_sequencer.sv
// fp_adder_sequencer: loads an operand pair into FP_Adder's serial lanes and reads back the sum.
// Optional build macro FP_SEQ_TIMEOUT_EN adds the WAIT_RES watchdog and sticky err_timeout.
module fp_adder_sequencer
  import fp_seq_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int LANES          = LANES_DEF,
  parameter int OCLK_DIV       = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic [LANES-1:0] fp_serial_out,
  output logic             fp_setup_serial,
  output logic             fp_wr,
  output logic             fp_output_clk,
  input  logic             fp_input_rdy,
  input  logic             fp_output_rdy,
  input  logic             fp_serial_in,
  output logic             err_timeout
);

  localparam int HW  = WIDTH / 2;
  localparam int BCW = $clog2(HW);
  localparam int RCW = $clog2(WIDTH);

  seq_state_e       state_r;
  seq_state_e       state_nx_s;
  logic [HW-1:0]    sh_r [LANES];
  logic [BCW-1:0]   bit_cnt_r;
  logic [RCW-1:0]   rd_cnt_r;
  logic [WIDTH-1:0] cap_r;
  logic             read_en_s;
  logic             sample_s;
  logic             bit_done_s;
  logic             timeout_s;

  assign read_en_s = (state_r == READ);

  fp_seq_oclk_gen #(.OCLK_DIV(OCLK_DIV)) u_oclk (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .en       (read_en_s),
    .oclk     (fp_output_clk),
    .sample   (sample_s),
    .bit_done (bit_done_s)
  );

`ifdef FP_SEQ_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_cnt_r;

  // Watchdog: counts consecutive WAIT_RES cycles
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt_r <= '0;
    end else if (state_r == WAIT_RES) begin
      to_cnt_r <= to_cnt_r + TCW'(1);
    end else begin
      to_cnt_r <= '0;
    end
  end

  assign timeout_s = (state_r == WAIT_RES) && (to_cnt_r == TCW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_valid && op_ready) state_nx_s = WAIT_RDY;
        else                      state_nx_s = IDLE;
      end
      WAIT_RDY: begin
        if (fp_input_rdy) state_nx_s = SHIFT;
        else              state_nx_s = WAIT_RDY;
      end
      SHIFT: begin
        if (bit_cnt_r == BCW'(HW - 1)) state_nx_s = WRITE;
        else                           state_nx_s = SHIFT;
      end
      WRITE: state_nx_s = WAIT_RES;
      WAIT_RES: begin
        if (fp_output_rdy)  state_nx_s = READ;
        else if (timeout_s) state_nx_s = DONE;
        else                state_nx_s = WAIT_RES;
      end
      READ: begin
        if (bit_done_s && (rd_cnt_r == RCW'(WIDTH - 1))) state_nx_s = DONE;
        else                                              state_nx_s = READ;
      end
      DONE: begin
        if (res_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and state-decoded outputs, registered against the next state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r         <= IDLE;
      op_ready        <= 1'b1;
      busy            <= 1'b0;
      res_valid       <= 1'b0;
      fp_wr           <= 1'b0;
      fp_setup_serial <= 1'b0;
    end else begin
      state_r         <= state_nx_s;
      op_ready        <= (state_nx_s == IDLE);
      busy            <= (state_nx_s != IDLE);
      res_valid       <= (state_nx_s == DONE);
      fp_wr           <= (state_nx_s == WRITE);
      fp_setup_serial <= (state_nx_s == SHIFT);
    end
  end

  // Operand shift registers and serial lane drivers (MSB first)
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int l = 0; l < LANES; l++) sh_r[l] <= '0;
      fp_serial_out <= '0;
      bit_cnt_r     <= '0;
    end else begin
      if ((state_r == IDLE) && (state_nx_s == WAIT_RDY)) begin
        sh_r[LANE_A_HI] <= op_a[WIDTH-1:HW];
        sh_r[LANE_A_LO] <= op_a[HW-1:0];
        sh_r[LANE_B_HI] <= op_b[WIDTH-1:HW];
        sh_r[LANE_B_LO] <= op_b[HW-1:0];
      end else if (state_nx_s == SHIFT) begin
        for (int l = 0; l < LANES; l++) sh_r[l] <= {sh_r[l][HW-2:0], 1'b0};
      end
      for (int l = 0; l < LANES; l++) begin
        fp_serial_out[l] <= (state_nx_s == SHIFT) ? sh_r[l][HW-1] : 1'b0;
      end
      bit_cnt_r <= (state_r == SHIFT) ? bit_cnt_r + BCW'(1) : '0;
    end
  end

  // Result capture; a watchdog exit reports an all-zero result
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cap_r    <= '0;
      rd_cnt_r <= '0;
      res_data <= '0;
    end else begin
      if (sample_s) cap_r <= {cap_r[WIDTH-2:0], fp_serial_in};
      if (state_r != READ) rd_cnt_r <= '0;
      else if (bit_done_s) rd_cnt_r <= rd_cnt_r + RCW'(1);
      if ((state_r == READ) && (state_nx_s == DONE))          res_data <= cap_r;
      else if ((state_r == WAIT_RES) && (state_nx_s == DONE)) res_data <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_timeout <= 1'b0;
    end else begin
`ifdef FP_SEQ_TIMEOUT_EN
      if ((state_r == WAIT_RES) && (state_nx_s == DONE)) err_timeout <= 1'b1;
`else
      err_timeout <= 1'b0;
`endif
    end
  end

endmodule
